// File: rtl/hazard_pkg.sv
// Shared types and constants for the Execute-stage hazard control unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN      = 1'b0,
    PAU_BUSY = 1'b1
  } state_e;

  localparam logic [1:0] MEMTOREG_LOAD = 2'b01;
  localparam logic [3:0] PC_REG        = 4'd15;

  // The younger producer (MEM) holds the newer value.
  function automatic fwd_sel_e fwd_pick(
    input logic mem_hit,
    input logic wb_hit
  );
    fwd_sel_e sel;
    sel = FWD_RF;
    if (mem_hit)     sel = FWD_MEM;
    else if (wb_hit) sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline <-> hazard unit bundle: stage register fields in,
// stall/flush/forward controls out.
interface hazard_control_unit_if #(
  parameter int RA_W = 4
);
  logic [RA_W-1:0] id_ra;
  logic [RA_W-1:0] id_rb;
  logic            id_use_ra;
  logic            id_use_rb;
  logic [RA_W-1:0] ex_rd;
  logic            ex_regwrite;
  logic [1:0]      ex_memtoreg;
  logic            ex_pau;
  logic            ex_pcsrc;
  logic [RA_W-1:0] mem_rd;
  logic            mem_regwrite;
  logic [RA_W-1:0] wb_rd;
  logic            wb_regwrite;
  logic            stall_f;
  logic            stall_d;
  logic            stall_e;
  logic            flush_d;
  logic            flush_e;
  logic [1:0]      fwd_a_sel;
  logic [1:0]      fwd_b_sel;
  logic            pau_busy;

  modport master (
    output id_ra, id_rb, id_use_ra, id_use_rb,
    output ex_rd, ex_regwrite, ex_memtoreg,
    output ex_pau, ex_pcsrc,
    output mem_rd, mem_regwrite,
    output wb_rd, wb_regwrite,
    input  stall_f, stall_d, stall_e,
    input  flush_d, flush_e,
    input  fwd_a_sel, fwd_b_sel, pau_busy
  );

  modport slave (
    input  id_ra, id_rb, id_use_ra, id_use_rb,
    input  ex_rd, ex_regwrite, ex_memtoreg,
    input  ex_pau, ex_pcsrc,
    input  mem_rd, mem_regwrite,
    input  wb_rd, wb_regwrite,
    output stall_f, stall_d, stall_e,
    output flush_d, flush_e,
    output fwd_a_sel, fwd_b_sel, pau_busy
  );
endinterface

// File: rtl/hazard_match.sv
// One source/stage RAW compare, qualified by use, regwrite and R15.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int RA_W = 4
) (
  input  logic [RA_W-1:0] rs_i,
  input  logic            use_i,
  input  logic [RA_W-1:0] rd_i,
  input  logic            we_i,
  output logic            hit_o
);

  assign hit_o = use_i & we_i
               & (rs_i == rd_i)
               & (rs_i != RA_W'(PC_REG));

endmodule

// File: rtl/hazard_control_unit.sv
// Execute-stage hazard sequencer: load-use, PAU and branch stall/flush.
// HAZARD_FORWARD_EN selects MEM/WB forwarding; undefined, RAW hazards stall.
module hazard_control_unit #(
  parameter int PAU_LAT = 3,
  parameter int RA_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_control_unit_if.slave hz
);
  import hazard_pkg::*;

  localparam int CW = (PAU_LAT > 2) ? $clog2(PAU_LAT - 1) : 1;

  logic a_ex, b_ex, a_mem, b_mem;

  hazard_match #(.RA_W(RA_W)) u_a_ex (
    .rs_i  (hz.id_ra),
    .use_i (hz.id_use_ra),
    .rd_i  (hz.ex_rd),
    .we_i  (hz.ex_regwrite),
    .hit_o (a_ex)
  );

  hazard_match #(.RA_W(RA_W)) u_b_ex (
    .rs_i  (hz.id_rb),
    .use_i (hz.id_use_rb),
    .rd_i  (hz.ex_rd),
    .we_i  (hz.ex_regwrite),
    .hit_o (b_ex)
  );

  hazard_match #(.RA_W(RA_W)) u_a_mem (
    .rs_i  (hz.id_ra),
    .use_i (hz.id_use_ra),
    .rd_i  (hz.mem_rd),
    .we_i  (hz.mem_regwrite),
    .hit_o (a_mem)
  );

  hazard_match #(.RA_W(RA_W)) u_b_mem (
    .rs_i  (hz.id_rb),
    .use_i (hz.id_use_rb),
    .rd_i  (hz.mem_rd),
    .we_i  (hz.mem_regwrite),
    .hit_o (b_mem)
  );

  logic load_use;
  logic raw_stall;

  assign load_use = (hz.ex_memtoreg == MEMTOREG_LOAD)
                  & (a_ex | b_ex);

`ifdef HAZARD_FORWARD_EN
  logic a_wb, b_wb;

  hazard_match #(.RA_W(RA_W)) u_a_wb (
    .rs_i  (hz.id_ra),
    .use_i (hz.id_use_ra),
    .rd_i  (hz.wb_rd),
    .we_i  (hz.wb_regwrite),
    .hit_o (a_wb)
  );

  hazard_match #(.RA_W(RA_W)) u_b_wb (
    .rs_i  (hz.id_rb),
    .use_i (hz.id_use_rb),
    .rd_i  (hz.wb_rd),
    .we_i  (hz.wb_regwrite),
    .hit_o (b_wb)
  );

  assign raw_stall = load_use;
`else
  // WB writes the RF in the first half-cycle, so only EX/MEM must wait.
  assign raw_stall = load_use | a_ex | b_ex | a_mem | b_mem;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            pau_stall;
  logic            haz_stall;
  logic            br_flush;

  // done_q marks the release cycle: the PAU op is still in Execute
  // but must not restart the sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    pau_stall = 1'b0;
    haz_stall = 1'b0;
    br_flush  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hz.ex_pau && (PAU_LAT > 1) && !done_q) begin
          pau_stall = 1'b1;
          if (PAU_LAT > 2) begin
            state_d = PAU_BUSY;
            cnt_d   = CW'(PAU_LAT - 2);
          end else begin
            done_d = 1'b1;
          end
        end else if (hz.ex_pcsrc) begin
          br_flush = 1'b1;
        end else begin
          haz_stall = raw_stall;
        end
      end
      PAU_BUSY: begin
        pau_stall = 1'b1;
        cnt_d     = cnt_q - CW'(1);
        if (cnt_d == '0) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  logic stall_fd;
  logic flush_e;

  assign stall_fd = ~rst & (pau_stall | haz_stall);
  assign flush_e  = rst | br_flush | haz_stall;

  assign hz.stall_f  = stall_fd;
  assign hz.stall_d  = stall_fd;
  assign hz.stall_e  = ~rst & pau_stall;
  assign hz.flush_d  = rst | br_flush;
  assign hz.flush_e  = flush_e;
  assign hz.pau_busy = (state_q == PAU_BUSY);

`ifdef HAZARD_FORWARD_EN
  fwd_sel_e fwd_a_q, fwd_a_d;
  fwd_sel_e fwd_b_q, fwd_b_d;

  always_comb begin
    fwd_a_d = fwd_pick(a_mem, a_wb);
    fwd_b_d = fwd_pick(b_mem, b_wb);
  end

  // A bubble in Execute carries no operands, so it reads the RF.
  always_ff @(posedge clk) begin
    if (flush_e) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (!stall_fd) begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign hz.fwd_a_sel = fwd_a_q;
  assign hz.fwd_b_sel = fwd_b_q;
`else
  assign hz.fwd_a_sel = FWD_RF;
  assign hz.fwd_b_sel = FWD_RF;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed table, corner sequences,
// and random traffic against an occupancy-based reference model.
module tb_hazard_control_unit;
  import hazard_pkg::*;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_control_unit_if #(.RA_W(4)) hz ();

  hazard_control_unit #(
    .PAU_LAT (LAT),
    .RA_W    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [1:0] act,
                     input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle();
    hz.id_ra = 4'd0; hz.id_rb = 4'd0;
    hz.id_use_ra = 1'b0; hz.id_use_rb = 1'b0;
    hz.ex_rd = 4'd0; hz.ex_regwrite = 1'b0;
    hz.ex_memtoreg = 2'b00;
    hz.ex_pau = 1'b0; hz.ex_pcsrc = 1'b0;
    hz.mem_rd = 4'd0; hz.mem_regwrite = 1'b0;
    hz.wb_rd = 4'd0; hz.wb_regwrite = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic hit(input logic [3:0] rs,
                               input logic u,
                               input logic [3:0] rd,
                               input logic w);
    return u && w && (rs == rd) && (rs != 4'd15);
  endfunction

  function automatic logic [3:0] rnd_reg();
    if ($urandom_range(0, 9) == 0) return 4'd15;
    return 4'($urandom_range(0, 5));
  endfunction

  typedef struct {
    logic [3:0] ra, rb;
    logic       ua, ub;
    logic [3:0] exrd;
    logic       exwe;
    logic [1:0] mtr;
    logic       pc;
    logic [3:0] mrd;
    logic       mwe;
    logic [3:0] wrd;
    logic       wwe;
    logic       sf, fe, fd;
    logic [1:0] fa, fb;
    logic       sn, fen;
  } vec_t;

  vec_t tbl [12];

  int         age;
  logic [1:0] mfa, mfb;

  initial begin
    int k, se_cnt;
    logic ps, eb, la, lb, ma, mb, wa, wb, haz;
    logic esf, ese, efd, efe;
    logic [1:0] nfa, nfb;

    tbl[0]  = '{1,2,1,1, 7,1,2'b01,0, 8,1,9,1,   0,0,0,0,0, 0,0};
    tbl[1]  = '{3,2,1,1, 3,1,2'b01,0, 8,1,9,1,   1,1,0,0,0, 1,1};
    tbl[2]  = '{1,4,0,1, 4,1,2'b01,0, 8,1,9,1,   1,1,0,0,0, 1,1};
    tbl[3]  = '{6,2,1,1, 6,1,2'b00,0, 8,1,9,1,   0,0,0,0,0, 1,1};
    tbl[4]  = '{0,5,0,1, 0,0,2'b00,0, 5,1,5,1,   0,0,0,0,1, 1,1};
    tbl[5]  = '{15,15,1,1, 15,1,2'b01,0, 15,1,15,1, 0,0,0,0,0, 0,0};
    tbl[6]  = '{9,3,1,1, 0,0,2'b00,0, 2,1,9,1,   0,0,0,2,0, 0,0};
    tbl[7]  = '{5,5,0,0, 5,1,2'b01,0, 5,1,5,1,   0,0,0,0,0, 0,0};
    tbl[8]  = '{5,5,1,1, 5,0,2'b01,0, 5,0,5,0,   0,0,0,0,0, 0,0};
    tbl[9]  = '{3,2,1,1, 3,1,2'b01,1, 8,1,9,1,   0,1,1,0,0, 0,1};
    tbl[10] = '{5,9,1,1, 0,0,2'b00,0, 5,1,9,1,   0,0,0,1,2, 1,1};
    tbl[11] = '{5,2,1,0, 0,0,2'b00,1, 5,1,9,1,   0,1,1,0,0, 0,1};

    // Reset held two cycles.
    idle();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_flush_d", hz.flush_d, 1);
      chk("rst_flush_e", hz.flush_e, 1);
      chk("rst_stall_f", hz.stall_f, 0);
      chk("rst_stall_d", hz.stall_d, 0);
      chk("rst_stall_e", hz.stall_e, 0);
      if (c == 1) begin
        chk("rst_fwd_a", hz.fwd_a_sel, 0);
        chk("rst_fwd_b", hz.fwd_b_sel, 0);
        chk("rst_pau_busy", hz.pau_busy, 0);
      end
      tick();
    end
    rst = 1'b0;

    // Directed single-cycle vectors, each from a clean reset.
    for (int i = 0; i < 12; i++) begin
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      hz.id_ra = tbl[i].ra; hz.id_rb = tbl[i].rb;
      hz.id_use_ra = tbl[i].ua; hz.id_use_rb = tbl[i].ub;
      hz.ex_rd = tbl[i].exrd; hz.ex_regwrite = tbl[i].exwe;
      hz.ex_memtoreg = tbl[i].mtr; hz.ex_pcsrc = tbl[i].pc;
      hz.mem_rd = tbl[i].mrd; hz.mem_regwrite = tbl[i].mwe;
      hz.wb_rd = tbl[i].wrd; hz.wb_regwrite = tbl[i].wwe;
      @(negedge clk);
`ifdef HAZARD_FORWARD_EN
      chk($sformatf("v%0d_stall_f", i), hz.stall_f, tbl[i].sf);
      chk($sformatf("v%0d_stall_d", i), hz.stall_d, tbl[i].sf);
      chk($sformatf("v%0d_flush_e", i), hz.flush_e, tbl[i].fe);
`else
      chk($sformatf("v%0d_stall_f", i), hz.stall_f, tbl[i].sn);
      chk($sformatf("v%0d_stall_d", i), hz.stall_d, tbl[i].sn);
      chk($sformatf("v%0d_flush_e", i), hz.flush_e, tbl[i].fen);
`endif
      chk($sformatf("v%0d_flush_d", i), hz.flush_d, tbl[i].fd);
      chk($sformatf("v%0d_stall_e", i), hz.stall_e, 0);
      tick();
      idle();
      @(negedge clk);
`ifdef HAZARD_FORWARD_EN
      chk($sformatf("v%0d_fwd_a", i), hz.fwd_a_sel, tbl[i].fa);
      chk($sformatf("v%0d_fwd_b", i), hz.fwd_b_sel, tbl[i].fb);
`else
      chk($sformatf("v%0d_fwd_a", i), hz.fwd_a_sel, 0);
      chk($sformatf("v%0d_fwd_b", i), hz.fwd_b_sel, 0);
`endif
      tick();
    end

    // Load-use followed by the load moving down the pipe.
    idle();
    hz.id_ra = 4'd3; hz.id_use_ra = 1'b1;
    hz.ex_rd = 4'd3; hz.ex_regwrite = 1'b1;
    hz.ex_memtoreg = 2'b01;
    @(negedge clk);
    chk("lu0_stall_d", hz.stall_d, 1);
    chk("lu0_flush_e", hz.flush_e, 1);
    tick();
    hz.ex_regwrite = 1'b0; hz.ex_memtoreg = 2'b00;
    hz.mem_rd = 4'd3; hz.mem_regwrite = 1'b1;
    @(negedge clk);
`ifdef HAZARD_FORWARD_EN
    chk("lu1_stall_d", hz.stall_d, 0);
    chk("lu1_fwd_a", hz.fwd_a_sel, 0);
`else
    chk("lu1_stall_d", hz.stall_d, 1);
`endif
    tick();
    hz.mem_regwrite = 1'b0;
    hz.wb_rd = 4'd3; hz.wb_regwrite = 1'b1;
    @(negedge clk);
    chk("lu2_stall_d", hz.stall_d, 0);
`ifdef HAZARD_FORWARD_EN
    chk("lu2_fwd_a", hz.fwd_a_sel, 1);
`else
    chk("lu2_fwd_a", hz.fwd_a_sel, 0);
`endif
    tick();

    // PAU op with a branch pending: branch waits for release.
    idle();
    hz.ex_pau = 1'b1; hz.ex_pcsrc = 1'b1;
    se_cnt = 0;
    for (int c = 0; c < LAT; c++) begin
      @(negedge clk);
      if (hz.stall_e === 1'b1) se_cnt++;
      chk($sformatf("pau%0d_stall_e", c), hz.stall_e,
          (c < LAT - 1) ? 2'd1 : 2'd0);
      chk($sformatf("pau%0d_busy", c), hz.pau_busy,
          (c >= 1 && c < LAT - 1) ? 2'd1 : 2'd0);
      chk($sformatf("pau%0d_flush_d", c), hz.flush_d,
          (c == LAT - 1) ? 2'd1 : 2'd0);
      tick();
    end
    chk("pau_stall_cycles", 2'(se_cnt), 2'(LAT - 1));
    idle();
    tick();

    // Reset during PAU_BUSY aborts the sequence.
    hz.ex_pau = 1'b1;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rbusy_pau_busy", hz.pau_busy, 1);
    chk("rbusy_stall_e", hz.stall_e, 0);
    tick();
    rst = 1'b0;
    hz.ex_pau = 1'b0;
    @(negedge clk);
    chk("rabort_pau_busy", hz.pau_busy, 0);
    chk("rabort_stall_e", hz.stall_e, 0);
    chk("rabort_stall_f", hz.stall_f, 0);
    tick();

    // Random traffic against the reference model.
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    age = 0; mfa = 2'd0; mfb = 2'd0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      hz.id_ra = rnd_reg(); hz.id_rb = rnd_reg();
      hz.id_use_ra = 1'($urandom_range(0, 1));
      hz.id_use_rb = 1'($urandom_range(0, 1));
      hz.ex_rd = rnd_reg();
      hz.ex_regwrite = 1'($urandom_range(0, 1));
      hz.ex_memtoreg = 2'($urandom_range(0, 3));
      hz.ex_pau = ($urandom_range(0, 7) == 0);
      hz.ex_pcsrc = ($urandom_range(0, 7) == 0);
      hz.mem_rd = rnd_reg();
      hz.mem_regwrite = 1'($urandom_range(0, 1));
      hz.wb_rd = rnd_reg();
      hz.wb_regwrite = 1'($urandom_range(0, 1));
      @(negedge clk);

      // k = which Execute cycle of the current PAU op this is.
      k  = (age > 0) ? age : (hz.ex_pau ? 1 : 0);
      ps = (k > 0) && (k < LAT);
      eb = (age >= 2) && (age < LAT);
      la = hit(hz.id_ra, hz.id_use_ra, hz.ex_rd, hz.ex_regwrite);
      lb = hit(hz.id_rb, hz.id_use_rb, hz.ex_rd, hz.ex_regwrite);
      ma = hit(hz.id_ra, hz.id_use_ra, hz.mem_rd, hz.mem_regwrite);
      mb = hit(hz.id_rb, hz.id_use_rb, hz.mem_rd, hz.mem_regwrite);
      wa = hit(hz.id_ra, hz.id_use_ra, hz.wb_rd, hz.wb_regwrite);
      wb = hit(hz.id_rb, hz.id_use_rb, hz.wb_rd, hz.wb_regwrite);
`ifdef HAZARD_FORWARD_EN
      haz = (hz.ex_memtoreg == 2'b01) && (la || lb);
`else
      haz = la || lb || ma || mb;
`endif
      if (rst) begin
        esf = 0; ese = 0; efd = 1; efe = 1;
      end else if (ps) begin
        esf = 1; ese = 1; efd = 0; efe = 0;
      end else if (hz.ex_pcsrc) begin
        esf = 0; ese = 0; efd = 1; efe = 1;
      end else begin
        esf = haz; ese = 0; efd = 0; efe = haz;
      end

      chk("rnd_stall_f", hz.stall_f, esf);
      chk("rnd_stall_d", hz.stall_d, esf);
      chk("rnd_stall_e", hz.stall_e, ese);
      chk("rnd_flush_d", hz.flush_d, efd);
      chk("rnd_flush_e", hz.flush_e, efe);
      chk("rnd_pau_busy", hz.pau_busy, eb);
      chk("rnd_fwd_a", hz.fwd_a_sel, mfa);
      chk("rnd_fwd_b", hz.fwd_b_sel, mfb);

`ifdef HAZARD_FORWARD_EN
      if (efe) begin
        nfa = 2'd0; nfb = 2'd0;
      end else if (!esf) begin
        nfa = ma ? 2'd1 : (wa ? 2'd2 : 2'd0);
        nfb = mb ? 2'd1 : (wb ? 2'd2 : 2'd0);
      end else begin
        nfa = mfa; nfb = mfb;
      end
`else
      nfa = 2'd0; nfb = 2'd0;
      wa = wa; wb = wb;
`endif
      tick();
      age = rst ? 0 : (ps ? k + 1 : 0);
      mfa = nfa;
      mfb = nfb;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
